mem_port_arbiter: RTL and testbench

Arbiter and sequencer for the single unified memory port shared by instruction fetch (IF) and the MEM-stage data access driven from the EX/MEM pipeline register. Grants the port to one requester at a time, with data over fetch, and runs a req/ack handshake of variable latency. It generates the stall signals that hold the PC, IF/ID and EX/MEM registers until each access completes, and counts stall cycles for performance analysis.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/sat_counter.sv | 26 ++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: memory-port arbiter states and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arbState_t;

  localparam int PIPE_ADDR_W = 64;
  localparam int PIPE_DATA_W = 64;
  localparam int PIPE_CNT_W  = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] countR;

  // Count register with synchronous clear and saturation at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      countR <= '0;
    end else if (inc && (countR != {W{1'b1}})) begin
      countR <= countR + {{(W-1){1'b0}}, 1'b1};
    end else begin
      countR <= countR;
    end
  end

  assign count = countR;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the unified memory port shared by instruction fetch
// and the MEM-stage data access. Data has priority; one transaction at a time.
module mem_port_arbiter
  import pipe_pkg::*;
#(
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              flush,
  input  logic              ex_mem_memread,
  input  logic              ex_mem_memwrite,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  input  logic [DATA_W-1:0] ex_mem_wdata,
  input  logic              port_ack,
  input  logic [DATA_W-1:0] port_rdata,
  output logic              port_req,
  output logic              port_we,
  output logic [ADDR_W-1:0] port_addr,
  output logic [DATA_W-1:0] port_wdata,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [CNT_W-1:0]  stall_cnt
);

  arbState_t         state;
  arbState_t         stateNext;
  logic              grantData;
  logic              grantFetch;
  logic              dataPend;
  logic              fetchPend;
  logic              dropFlag;
  logic              fetchHigh;
  logic              weR;
  logic [ADDR_W-1:0] addrR;
  logic [DATA_W-1:0] wdataR;
  logic              ifValidR;
  logic [31:0]       ifRdataR;
  logic              memDoneR;
  logic [DATA_W-1:0] memRdataR;

  // A requester whose completion pulse is high is not re-granted: the
  // pipeline is advancing past it this cycle.
  assign dataPend  = (ex_mem_memread | ex_mem_memwrite) & ~memDoneR;
  assign fetchPend = if_req & ~ifValidR & ~flush;

  assign stall_mem = dataPend;
  assign stall_if  = dataPend | (if_req & ~ifValidR);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and grant decode; data wins over fetch.
  always_comb begin
    stateNext  = state;
    grantData  = 1'b0;
    grantFetch = 1'b0;
    case (state)
      IDLE: begin
        if (dataPend) begin
          stateNext = DATA;
          grantData = 1'b1;
        end else if (fetchPend) begin
          stateNext  = FETCH;
          grantFetch = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
      FETCH, DATA: begin
        if (port_ack) begin
          stateNext = IDLE;
        end else begin
          stateNext = state;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Request latching, drop tracking and completion pulses/result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      addrR     <= '0;
      weR       <= 1'b0;
      wdataR    <= '0;
      fetchHigh <= 1'b0;
      dropFlag  <= 1'b0;
      ifValidR  <= 1'b0;
      ifRdataR  <= '0;
      memDoneR  <= 1'b0;
      memRdataR <= '0;
    end else begin
      ifValidR <= 1'b0;
      memDoneR <= 1'b0;
      if (grantData) begin
        addrR  <= ex_mem_addr;
        weR    <= ex_mem_memwrite;
        wdataR <= ex_mem_wdata;
      end else if (grantFetch) begin
        addrR     <= {if_addr[ADDR_W-1:3], 3'b000};
        weR       <= 1'b0;
        fetchHigh <= if_addr[2];
      end
      // Drop flag lives only for the duration of one fetch transaction.
      if ((state == FETCH) && !port_ack) begin
        dropFlag <= dropFlag | flush;
      end else begin
        dropFlag <= 1'b0;
      end
      if ((state == FETCH) && port_ack && !(dropFlag || flush)) begin
        ifValidR <= 1'b1;
        ifRdataR <= fetchHigh ? port_rdata[63:32] : port_rdata[31:0];
      end
      if ((state == DATA) && port_ack) begin
        memDoneR <= 1'b1;
        if (!weR) begin
          memRdataR <= port_rdata;
        end
      end
    end
  end

  assign port_req   = (state != IDLE);
  assign port_we    = weR;
  assign port_addr  = addrR;
  assign port_wdata = wdataR;
  assign if_valid   = ifValidR;
  assign if_rdata   = ifRdataR;
  assign mem_done   = memDoneR;
  assign mem_rdata  = memRdataR;

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_if),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          flush;
  logic          ex_mem_memread;
  logic          ex_mem_memwrite;
  logic [AW-1:0] ex_mem_addr;
  logic [DW-1:0] ex_mem_wdata;
  logic          port_ack;
  logic [DW-1:0] port_rdata;
  logic          port_req;
  logic          port_we;
  logic [AW-1:0] port_addr;
  logic [DW-1:0] port_wdata;
  logic          if_valid;
  logic [31:0]   if_rdata;
  logic          mem_done;
  logic [DW-1:0] mem_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic [CW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .ex_mem_memread(ex_mem_memread), .ex_mem_memwrite(ex_mem_memwrite),
    .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
    .port_ack(port_ack), .port_rdata(port_rdata),
    .port_req(port_req), .port_we(port_we), .port_addr(port_addr),
    .port_wdata(port_wdata), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .stall_if(stall_if),
    .stall_mem(stall_mem), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
    ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0; ex_mem_addr = '0;
    ex_mem_wdata = '0; port_ack = 1'b0; port_rdata = '0;
    tick(2);
    reset = 1'b0;
    check("rst_req",   port_req,  1'b0);
    check("rst_valid", if_valid,  1'b0);
    check("rst_done",  mem_done,  1'b0);
    check("rst_addr",  port_addr, 64'h0);
    check("rst_cnt",   stall_cnt, 4'd0);

    // Fetch with immediate ack, upper half selected by addr[2].
    if_req = 1'b1; if_addr = 64'h1004;
    #1 check("f1_stall_if", stall_if, 1'b1);
    tick();
    check("f1_req",  port_req,  1'b1);
    check("f1_addr", port_addr, 64'h1000);
    check("f1_we",   port_we,   1'b0);
    port_ack = 1'b1; port_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    check("f1_valid",  if_valid,  1'b1);
    check("f1_rdata",  if_rdata,  32'hAAAABBBB);
    check("f1_reqlo",  port_req,  1'b0);
    check("f1_stall0", stall_if,  1'b0);
    check("f1_cnt",    stall_cnt, 4'd2);
    if_req = 1'b0; port_ack = 1'b0;
    tick();
    check("f1_pulse1", if_valid, 1'b0);

    // Ack with no request outstanding is ignored.
    port_ack = 1'b1; port_rdata = 64'h5;
    tick();
    port_ack = 1'b0;
    tick();
    check("idle_ack_v", if_valid, 1'b0);
    check("idle_ack_d", mem_done, 1'b0);
    check("idle_ack_r", port_req, 1'b0);

    // Concurrent load and fetch: data first, fetch granted in mem_done cycle.
    ex_mem_memread = 1'b1; ex_mem_addr = 64'h2000; if_req = 1'b1; if_addr = 64'h3000;
    tick();
    check("c_addr_d", port_addr, 64'h2000);
    check("c_we_d",   port_we,   1'b0);
    check("c_stall",  stall_if,  1'b1);
    port_ack = 1'b1; port_rdata = 64'h1122_3344_5566_7788;
    tick();
    check("c_done",   mem_done,  1'b1);
    check("c_mrdata", mem_rdata, 64'h1122_3344_5566_7788);
    check("c_stallm", stall_mem, 1'b0);
    check("c_stallf", stall_if,  1'b1);
    ex_mem_memread = 1'b0; port_ack = 1'b0;
    tick();
    check("c_req_f",  port_req,  1'b1);
    check("c_addr_f", port_addr, 64'h3000);
    check("c_done0",  mem_done,  1'b0);
    port_ack = 1'b1; port_rdata = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    check("c_valid",  if_valid, 1'b1);
    check("c_rdata",  if_rdata, 32'hCAFEF00D);
    if_req = 1'b0; port_ack = 1'b0;
    tick();

    // Store with 4-cycle latency; no re-issue while pipeline advances.
    ex_mem_memwrite = 1'b1; ex_mem_addr = 64'h4008; ex_mem_wdata = 64'h0123_4567_89AB_CDEF;
    #1 check("s_stallm0", stall_mem, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("s_req",    port_req,   1'b1);
      check("s_we",     port_we,    1'b1);
      check("s_wdata",  port_wdata, 64'h0123_4567_89AB_CDEF);
      check("s_stallm", stall_mem,  1'b1);
      check("s_done0",  mem_done,   1'b0);
      if (i == 3) port_ack = 1'b1;
      tick();
    end
    check("s_done",   mem_done,  1'b1);
    check("s_mrhold", mem_rdata, 64'h1122_3344_5566_7788);
    check("s_stallm", stall_mem, 1'b0);
    check("s_reqlo",  port_req,  1'b0);
    port_ack = 1'b0;
    tick();
    ex_mem_memwrite = 1'b0;
    check("s_noreiss", port_req, 1'b0);
    check("s_onepuls", mem_done, 1'b0);
    tick();

    // Flush during FETCH drops the result; next fetch proceeds normally.
    if_req = 1'b1; if_addr = 64'h5000;
    tick();
    check("fl_req", port_req, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    port_ack = 1'b1; port_rdata = 64'h9999_9999_9999_9999;
    tick();
    check("fl_novalid", if_valid, 1'b0);
    check("fl_hold",    if_rdata, 32'hCAFEF00D);
    port_ack = 1'b0;
    tick();
    check("fl_regrant", port_req,  1'b1);
    check("fl_addr",    port_addr, 64'h5000);
    port_ack = 1'b1; port_rdata = 64'h7777_6666_5555_4444;
    tick();
    check("fl_valid", if_valid, 1'b1);
    check("fl_rdata", if_rdata, 32'h55554444);
    if_req = 1'b0; port_ack = 1'b0;
    tick();

    // Flush on the same cycle as the fetch ack drops the result.
    if_req = 1'b1; if_addr = 64'h6004;
    tick();
    flush = 1'b1; port_ack = 1'b1; port_rdata = 64'h1234_5678_0000_0000;
    tick();
    flush = 1'b0; port_ack = 1'b0; if_req = 1'b0;
    check("fa_novalid", if_valid, 1'b0);
    check("fa_hold",    if_rdata, 32'h55554444);
    tick();

    // Reset during DATA abandons the transaction.
    ex_mem_memread = 1'b1; ex_mem_addr = 64'h7000;
    tick();
    check("r_req1", port_req, 1'b1);
    reset = 1'b1; ex_mem_memread = 1'b0;
    tick();
    check("r_req0",   port_req,  1'b0);
    check("r_addr",   port_addr, 64'h0);
    check("r_mrdata", mem_rdata, 64'h0);
    check("r_ifrd",   if_rdata,  32'h0);
    check("r_cnt",    stall_cnt, 4'd0);
    reset = 1'b0;

    // Saturation: flush blocks the grant while stall_if stays high.
    if_req = 1'b1; flush = 1'b1;
    tick(14);
    check("sat_14", stall_cnt, 4'd14);
    tick();
    check("sat_15", stall_cnt, 4'd15);
    tick(5);
    check("sat_hold", stall_cnt, 4'd15);
    check("sat_noreq", port_req, 1'b0);
    if_req = 1'b0; flush = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
